// File: rtl/rpsc_pkg.sv
// Shared types and helpers for the RPSC permissive/ON latch card.
package rpsc_pkg;

   typedef enum logic [1:0] {
      SEQ_NORMAL  = 2'd0,
      SEQ_DROP    = 2'd1,
      SEQ_TRIPPED = 2'd2
   } seq_state_t;

   localparam int unsigned RPSC_SYNC_STAGES = 2;

   // Index width that never collapses to zero bits for one or two channels.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rpsc_debounce.sv
// Two-flop synchroniser followed by a consecutive-disagreement debounce filter.
module rpsc_debounce
   import rpsc_pkg::*;
#(
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic d_raw,
   output logic d_filt
);

   localparam int unsigned CW = $clog2(DEBOUNCE + 1);

   logic [RPSC_SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic                        filt_q, filt_d;

   // Counter only advances while the synchronised sample disagrees with the
   // filtered value; any agreeing sample restarts the count.
   always_comb begin
      sync_d = {sync_q[RPSC_SYNC_STAGES-2:0], d_raw};
      cnt_d  = '0;
      filt_d = filt_q;
      if (sync_q[RPSC_SYNC_STAGES-1] != filt_q) begin
         if (cnt_q == CW'(DEBOUNCE - 1)) begin
            filt_d = ~filt_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         cnt_q  <= '0;
         filt_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
      end
   end

   assign d_filt = filt_q;

endmodule

// File: rtl/rpsc_perm_seq_latch.sv
// Ordered permissive/ON latch card: filtered inputs, sequenced power-up and
// reverse-order trip shutdown with a latched fault and tripping channel index.
module rpsc_perm_seq_latch
   import rpsc_pkg::*;
#(
   parameter int unsigned    N_CH      = 4,
   parameter int unsigned    DEBOUNCE  = 4,
   parameter int unsigned    STEP_DLY  = 16,
   parameter logic [N_CH-1:0] ECHO_MASK = N_CH'(4'b0011)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_CH-1:0]               perm_in,
   input  logic [N_CH-1:0]               on_in,
   input  logic                          clr,
   output logic [N_CH-1:0]               perm_la,
   output logic [N_CH-1:0]               on_la,
   output logic [N_CH-1:0]               on_ep1,
   output logic                          fault,
   output logic [clog2_min1(N_CH)-1:0]   trip_ch
);

   localparam int unsigned TCW = clog2_min1(N_CH);
   localparam int unsigned TW  = $clog2(STEP_DLY + 1);
   localparam logic [TW-1:0] STEP_LOAD = TW'(STEP_DLY - 1);

   logic [N_CH-1:0] fp, fo;
   seq_state_t      state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [TCW-1:0]  trip_ch_q, trip_ch_d;
   logic [N_CH-1:0] perm_la_q;
   logic [N_CH-1:0] on_la_q, on_la_d;
   logic [N_CH-1:0] on_ep1_q;
   logic            fault_q, fault_d;

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      rpsc_debounce #(
         .DEBOUNCE (DEBOUNCE)
      ) u_perm (
         .clk    (clk),
         .reset  (reset),
         .d_raw  (perm_in[k]),
         .d_filt (fp[k])
      );
      rpsc_debounce #(
         .DEBOUNCE (DEBOUNCE)
      ) u_on (
         .clk    (clk),
         .reset  (reset),
         .d_raw  (on_in[k]),
         .d_filt (fo[k])
      );
   end

   // on_up[k] = on_la[k+1] (0 above the top); on_dn[k] = on_la[k-1] (1 below channel 0).
   logic [N_CH-1:0] on_up, on_dn;
   logic [N_CH-1:0] trip_vec, set_ok, clr_ok;
   logic            trip_any;
   logic [TCW-1:0]  trip_lo;

   always_comb begin
      on_up    = on_la_q >> 1;
      on_dn    = (on_la_q << 1) | N_CH'(1);
      trip_vec = (on_la_q & ~fp) | (~fo & on_up);
      trip_any = |trip_vec;
      set_ok   = fo & perm_la_q & on_dn;
      clr_ok   = ~fo & ~on_up;
   end

   always_comb begin
      trip_lo = '0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (trip_vec[k]) trip_lo = TCW'(k);
      end
   end

   // Effective trip index this cycle: a fresh lower trip in DROP extends the
   // sequence downward immediately, so masks and the drop pick use it at once.
   logic [TCW-1:0]  tc_eff;
   logic [N_CH-1:0] ge_mask, drop_oh;

   always_comb begin
      tc_eff = trip_ch_q;
      if (state_q == SEQ_NORMAL) begin
         tc_eff = trip_lo;
      end else if (state_q == SEQ_DROP && trip_any && trip_lo < trip_ch_q) begin
         tc_eff = trip_lo;
      end
   end

   always_comb begin
      ge_mask = '0;
      drop_oh = '0;
      for (int k = 0; k < N_CH; k++) begin
         ge_mask[k] = (TCW'(k) >= tc_eff);
         if (on_la_q[k] && (TCW'(k) >= tc_eff)) begin
            drop_oh    = '0;
            drop_oh[k] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      on_la_d   = on_la_q;
      trip_ch_d = trip_ch_q;
      timer_d   = timer_q;
      unique case (state_q)
         SEQ_NORMAL: begin
            if (trip_any) begin
               state_d   = SEQ_DROP;
               trip_ch_d = trip_lo;
               timer_d   = STEP_LOAD;
               on_la_d   = on_la_q & ~drop_oh;
            end else begin
               on_la_d = (on_la_q | set_ok) & ~clr_ok;
            end
         end
         SEQ_DROP: begin
            trip_ch_d = tc_eff;
            on_la_d   = on_la_q & ~(clr_ok & ~ge_mask);
            if ((on_la_q & ge_mask) == '0) begin
               state_d = SEQ_TRIPPED;
            end else if (timer_q == '0) begin
               on_la_d = on_la_d & ~drop_oh;
               timer_d = STEP_LOAD;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         SEQ_TRIPPED: begin
            on_la_d = on_la_q & ~(clr_ok & ~ge_mask) & ~ge_mask;
            if (clr && fo == '0) begin
               state_d   = SEQ_NORMAL;
               trip_ch_d = '0;
            end
         end
         default: begin
            state_d = SEQ_NORMAL;
         end
      endcase
      fault_d = (state_d != SEQ_NORMAL);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= SEQ_NORMAL;
         timer_q   <= '0;
         trip_ch_q <= '0;
         perm_la_q <= '0;
         on_la_q   <= '0;
         on_ep1_q  <= '0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         trip_ch_q <= trip_ch_d;
         perm_la_q <= fp;
         on_la_q   <= on_la_d;
         on_ep1_q  <= on_la_d & ECHO_MASK;
         fault_q   <= fault_d;
      end
   end

   assign perm_la = perm_la_q;
   assign on_la   = on_la_q;
   assign on_ep1  = on_ep1_q;
   assign fault   = fault_q;
   assign trip_ch = trip_ch_q;

endmodule

// File: doc/rpsc_perm_seq_latch.md
# rpsc_perm_seq_latch

Parametrised permissive/ON latch card for the RPSC interlock chain. It generalises the fixed eight-flip-flop latch card (FAN, CA, G1, Anode) to `N_CH` ordered channels. It adds input synchronisation and debounce, enforced power-up order, and a sequenced reverse-order trip shutdown with a latched fault. It sits between the field permissive/ON inputs and the output-latch/EP1 echo drivers.

## Interface
- `N_CH`, default 4: number of ordered channels. Channel 0 is first on and last off.
- `DEBOUNCE`, default 4: consecutive stable synchronised samples required before a filtered input changes. Legal range is ≥1.
- `STEP_DLY`, default 16: cycles between successive channel drops during a trip. Legal range is ≥1.
- `ECHO_MASK`, default 4'b0011: channels whose ON latch is also driven on the EP1 echo output.
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `perm_in`  in  N_CH: raw permissive inputs, asynchronous.
- `on_in`  in  N_CH: raw ON request inputs, asynchronous.
- `clr`  in  1: fault acknowledge, synchronous, level-sensitive.
- `perm_la`  out  N_CH: latched, filtered permissive.
- `on_la`  out  N_CH: latched ON outputs.
- `on_ep1`  out  N_CH: equals `on_la & ECHO_MASK`, registered.
- `fault`  out  1: high in SEQ_DROP and SEQ_TRIPPED.
- `trip_ch`  out  $clog2(N_CH), minimum 1 bit: index of the lowest tripping channel. Held until clear.

## Operation
- Each of the 2·N_CH inputs passes through a 2-FF synchroniser and then a debounce filter.
  - The filter counter counts cycles in which the synchroniser output differs from the filtered value.
  - The counter resets on any agreeing sample.
  - The filtered value flips when the count reaches `DEBOUNCE`.
- `perm_la[k]` is the registered filtered permissive `fp[k]`, in every state.
- States (enum `seq_state_t`):
  - **SEQ_NORMAL**
    - `on_la[k]` sets when `fo[k]=1`, `perm_la[k]=1`, and either k=0 or `on_la[k-1]=1`.
    - `on_la[k]` clears when `fo[k]=0` and `on_la[k+1]=0`; the top channel needs only `fo[k]=0`.
  - **SEQ_DROP**
    - Entered on a trip condition.
    - The step timer loads `STEP_DLY-1`.
    - At each timer expiry, the highest set `on_la[h]` with h ≥ `trip_ch` clears and the timer reloads.
    - The first drop (the highest channel) occurs on the entry cycle itself.
    - The state moves to SEQ_TRIPPED when `on_la[trip_ch..N_CH-1]` are all 0.
    - No `on_la` bit may set in this state.
  - **SEQ_TRIPPED**
    - `on_la` bits from `trip_ch` upward are held at 0.
    - The state moves to SEQ_NORMAL when `clr=1` and all `fo` bits are 0.
    - `trip_ch` resets to 0 on that exit.
- Trip conditions, evaluated in SEQ_NORMAL and SEQ_DROP:
  - (a) `on_la[k]=1` and `fp[k]=0`.
  - (b) `fo[k]=0` while `on_la[k+1]=1`, i.e. an out-of-order release.
  - `trip_ch` becomes the lowest k meeting either condition.
  - In SEQ_DROP, `trip_ch` only ever decreases to a new lower k, and the drop sequence then extends down to it.
- Simultaneous events:
  - A trip condition beats a set or clear in the same cycle.
  - `clr` is ignored outside SEQ_TRIPPED.
  - `clr` held high while any `fo` bit is 1 keeps the block in SEQ_TRIPPED.
- Reset:
  - Clears all synchronisers, filters, counters, `perm_la`, `on_la`, `on_ep1`, `fault` and `trip_ch`. All are 0 on reset.
  - The state becomes SEQ_NORMAL.
  - Reset during SEQ_DROP clears all outputs immediately and aborts the sequence.

## Timing
- Raw input edge to filtered value change takes `DEBOUNCE+2` cycles: 2 synchroniser cycles plus `DEBOUNCE` filter cycles.
- Raw input edge to `perm_la`/`on_la` change takes `DEBOUNCE+3` cycles, which is 7 at the defaults.
- `on_ep1` lags `on_la` by 0 cycles; both come from the same register stage.
- Power-up chain: each channel sets one cycle after its lower neighbour at the earliest.
- Trip:
  - `fault` rises one cycle after the filtered trip condition.
  - The highest channel drops in the same cycle as `fault` rises.
  - Each later drop follows `STEP_DLY` cycles after the previous one.
  - Entry into SEQ_TRIPPED occurs one cycle after the last drop.
- Clear: `fault` falls one cycle after the `clr` sample in which all `fo` bits are 0.

## Structure
- Package `rpsc_pkg` holds:
  - `seq_state_t`.
  - A `RPSC_SYNC_STAGES=2` constant.
  - A `clog2_min1` helper function for the `trip_ch` width.
- Sub-module `rpsc_debounce`:
  - One instance per input bit, via a generate loop.
  - Parameter `DEBOUNCE`; ports `clk`, `reset`, `d_raw`, `d_filt`.
  - Contains the 2-FF synchroniser and counter.
- The top level holds the sequencing FSM, the step timer ($clog2(STEP_DLY+1) bits), the `trip_ch` register and the output registers.

## Test plan
- **Ordered power-up.** Defaults; all `perm_in=1`, then `on_in=4'b1111` together. Required response: `on_la` bits 0..3 set on cycles 7, 8, 9, 10 after the edge, and `on_ep1=4'b0011` at the end.
- **Glitch rejection.** A 3-cycle pulse on `perm_in[0]` with `DEBOUNCE=4` → no change on any output. A 4-cycle pulse → `perm_la[0]` pulses.
- **Permissive trip.** All channels on, then `perm_in[1]` drops.
  - `fault=1` and `trip_ch=1`.
  - `on_la[3]`, `on_la[2]` and `on_la[1]` clear 16 cycles apart, in that order.
  - `on_la[0]` stays at 1.
  - The block then enters SEQ_TRIPPED.
- **Out-of-order release and lower trip during DROP.**
  - Dropping `on_in[2]` while channel 3 is on → trip with `trip_ch=2`.
  - Mid-drop, `perm_in[0]` drops → `trip_ch` becomes 0 and all four channels end at 0.
- **Clear gating.**
  - `clr=1` while `on_in[0]` is still 1 → the block stays TRIPPED.
  - Release `on_in[0]`, then wait 7 cycles with `clr=1` → `fault=0`, the block returns to SEQ_NORMAL, and `trip_ch=0`.
- **Reset mid-drop.** Assert `reset` between two drop steps → all outputs are 0 immediately. After deassertion with inputs held high, the block repeats the ordered power-up.
